// File: rtl/riscv_mc_ctrl_if.sv
// rtl/riscv_mc_ctrl_if.sv - control/status bundle between the multi-cycle controller and the datapath/memory side
interface riscv_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic             mem_ready;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_we;
    logic             ir_we;
    logic             pc_we;
    logic             pc_sel;
    logic             rf_we;
    logic             alu_src;
    logic [3:0]       alu_op;
    logic [1:0]       wb_sel;
    logic             trap;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        input  opcode, func3, func7, mem_ready, branch_taken,
        output mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we,
               alu_src, alu_op, wb_sel, trap, retire_cnt
    );

    modport slave (
        output opcode, func3, func7, mem_ready, branch_taken,
        input  mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we,
               alu_src, alu_op, wb_sel, trap, retire_cnt
    );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// rtl/riscv_mc_ctrl.sv - RV32 multi-cycle control FSM with retired-instruction counter (optional CTRL_TRAP_EN)
module riscv_mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    riscv_mc_ctrl_if.master  bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_lui, is_legal;
    logic in_exe;
    logic [3:0] alu_op_dec;
    logic [1:0] wb_sel_dec;
    logic       alu_src_dec;

    // Only func7[5] selects SUB/SRA; the other bits are don't-care here.
    logic unused_func7;
    assign unused_func7 = ^{bus.func7[6], bus.func7[4:0]};

    // Opcode classification of the latched instruction.
    always_comb begin
        is_r      = (bus.opcode == OP_R);
        is_i      = (bus.opcode == OP_I);
        is_load   = (bus.opcode == OP_LOAD);
        is_store  = (bus.opcode == OP_STORE);
        is_branch = (bus.opcode == OP_BRANCH);
        is_jal    = (bus.opcode == OP_JAL);
        is_lui    = (bus.opcode == OP_LUI);
        is_legal  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_lui;
    end

    // ALU and writeback selects derived from the instruction fields.
    always_comb begin
        alu_op_dec = 4'b0000;
        if (is_r) begin
            alu_op_dec = {bus.func7[5], bus.func3};
        end else if (is_i) begin
            alu_op_dec = {(bus.func3 == 3'b101) ? bus.func7[5] : 1'b0, bus.func3};
        end else if (is_branch) begin
            alu_op_dec = 4'b1000;
        end

        alu_src_dec = !(is_r || is_branch);

        wb_sel_dec = 2'd0;
        if (is_load) begin
            wb_sel_dec = 2'd1;
        end else if (is_jal) begin
            wb_sel_dec = 2'd2;
        end else if (is_lui) begin
            wb_sel_dec = 2'd3;
        end
    end

    // Datapath selects are only presented once the instruction has been decoded,
    // and stay constant through EXEC/MEM/WB.
    assign in_exe      = (state_q == EXEC) || (state_q == MEM) || (state_q == WB);
    assign bus.alu_op  = in_exe ? alu_op_dec  : 4'b0000;
    assign bus.alu_src = in_exe ? alu_src_dec : 1'b0;
    assign bus.wb_sel  = in_exe ? wb_sel_dec  : 2'd0;

    // Next-state and strobe generation; everything defaults to idle.
    always_comb begin
        state_d     = state_q;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        bus.ir_we   = 1'b0;
        bus.pc_we   = 1'b0;
        bus.pc_sel  = 1'b0;
        bus.rf_we   = 1'b0;
        bus.trap    = 1'b0;
        retire      = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                if (is_legal) begin
                    state_d = EXEC;
                end else begin
`ifdef CTRL_TRAP_EN
                    state_d = TRAP;
`else
                    // Illegal opcode retires as a NOP: step the PC and refetch.
                    bus.pc_we = 1'b1;
                    retire    = 1'b1;
                    state_d   = FETCH;
`endif
                end
            end
            EXEC: begin
                if (is_branch) begin
                    bus.pc_we  = 1'b1;
                    bus.pc_sel = bus.branch_taken;
                    retire     = 1'b1;
                    state_d    = FETCH;
                end else if (is_load || is_store) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = is_store;
                if (bus.mem_ready) begin
                    if (is_store) begin
                        bus.pc_we = 1'b1;
                        retire    = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                bus.rf_we  = 1'b1;
                bus.pc_we  = 1'b1;
                bus.pc_sel = is_jal;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
`ifdef CTRL_TRAP_EN
                // Sticky until reset; counter is frozen because nothing retires.
                bus.trap = 1'b1;
                state_d  = TRAP;
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Retired-instruction counter wraps naturally at 2^CNT_W.
    assign cnt_d          = cnt_q + {{(CNT_W-1){1'b0}}, retire};
    assign bus.retire_cnt = cnt_q;

    // State register; async reset so mem_req drops the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb/tb_riscv_mc_ctrl.sv - scoreboard testbench for riscv_mc_ctrl
module tb_riscv_mc_ctrl;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_ILL    = 7'b1111111;

    typedef struct packed {
        logic [7:0]  pc_cyc;
        logic [7:0]  ir_cyc;
        logic [3:0]  ir_n;
        logic [3:0]  pc_n;
        logic [3:0]  rf_n;
        logic        pc_sel;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic [7:0]  dreq_n;
        logic [7:0]  we_n;
        logic [31:0] cnt;
        logic        timeout;
    } rec_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         fw;
        int         mw;
        logic       tk;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_mc_ctrl_if #(.CNT_W(32)) bus ();
    riscv_mc_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    rec_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;

    function automatic logic [12:0] ctrl_outs();
        return {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.pc_sel,
                bus.rf_we, bus.alu_src, bus.alu_op, bus.wb_sel};
    endfunction

    // Reference behaviour of one instruction starting in FETCH.
    function automatic rec_t model(input stim_t s, input logic [31:0] cnt_before);
        rec_t r;
        r        = '0;
        r.ir_n   = 4'd1;
        r.pc_n   = 4'd1;
        r.ir_cyc = 8'(1 + s.fw);
        r.cnt    = cnt_before + 32'd1;
        case (s.op)
            OP_R: begin
                r.pc_cyc = 8'(4 + s.fw); r.rf_n = 4'd1; r.rf_we = 1'b1;
                r.alu_op = {s.f7[5], s.f3};
            end
            OP_I: begin
                r.pc_cyc = 8'(4 + s.fw); r.rf_n = 4'd1; r.rf_we = 1'b1; r.alu_src = 1'b1;
                r.alu_op = {(s.f3 == 3'b101) ? s.f7[5] : 1'b0, s.f3};
            end
            OP_LUI: begin
                r.pc_cyc = 8'(4 + s.fw); r.rf_n = 4'd1; r.rf_we = 1'b1; r.alu_src = 1'b1;
                r.wb_sel = 2'd3;
            end
            OP_JAL: begin
                r.pc_cyc = 8'(4 + s.fw); r.rf_n = 4'd1; r.rf_we = 1'b1; r.alu_src = 1'b1;
                r.wb_sel = 2'd2; r.pc_sel = 1'b1;
            end
            OP_LOAD: begin
                r.pc_cyc = 8'(5 + s.fw + s.mw); r.rf_n = 4'd1; r.rf_we = 1'b1; r.alu_src = 1'b1;
                r.wb_sel = 2'd1; r.dreq_n = 8'(1 + s.mw);
            end
            OP_STORE: begin
                r.pc_cyc = 8'(4 + s.fw + s.mw); r.alu_src = 1'b1;
                r.dreq_n = 8'(1 + s.mw); r.we_n = 8'(1 + s.mw);
            end
            OP_BRANCH: begin
                r.pc_cyc = 8'(3 + s.fw); r.pc_sel = s.tk; r.alu_op = 4'b1000;
            end
            default: begin
                r.pc_cyc = 8'(2 + s.fw);
            end
        endcase
        return r;
    endfunction

    task automatic drive_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction from FETCH until its pc_we pulse; returns observations.
    task automatic run_instr(input stim_t s, output rec_t obs);
        int  phase = 0;
        int  wcnt  = 0;
        int  cyc   = 0;
        bit  done  = 0;
        obs = '0;
        bus.opcode = s.op;
        bus.func3  = s.f3;
        bus.func7  = s.f7;
        while (!done && cyc < 60) begin
            if (bus.mem_req) begin
                if (wcnt >= ((phase == 0) ? s.fw : s.mw)) begin
                    bus.mem_ready = 1'b1;
                end else begin
                    bus.mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            bus.branch_taken = s.tk;
            @(negedge clk);
            cyc++;
            if (bus.mem_req && phase == 1) obs.dreq_n = obs.dreq_n + 8'd1;
            if (bus.mem_we) obs.we_n = obs.we_n + 8'd1;
            if (bus.rf_we) obs.rf_n = obs.rf_n + 4'd1;
            if (bus.ir_we) begin
                obs.ir_n   = obs.ir_n + 4'd1;
                obs.ir_cyc = 8'(cyc);
                phase = 1;
                wcnt  = 0;
            end
            if (bus.pc_we) begin
                obs.pc_n    = obs.pc_n + 4'd1;
                obs.pc_cyc  = 8'(cyc);
                obs.pc_sel  = bus.pc_sel;
                obs.rf_we   = bus.rf_we;
                obs.wb_sel  = bus.wb_sel;
                obs.alu_op  = bus.alu_op;
                obs.alu_src = bus.alu_src;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        obs.timeout = !done;
        obs.cnt     = bus.retire_cnt;
    endtask

    // Pushes the expectation, runs the instruction, pops and compares.
    task automatic sb_run(input string name, input stim_t s);
        rec_t obs, e;
        exp_q.push_back(model(s, exp_cnt));
        run_instr(s, obs);
        e = exp_q.pop_front();
        n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, obs, e);
        end
        exp_cnt = e.cnt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        bus.opcode = 7'd0;
        bus.func3 = 3'd0;
        bus.func7 = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({ctrl_outs(), bus.trap, bus.retire_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h/%b/%h expected 0", ctrl_outs(), bus.trap, bus.retire_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({ctrl_outs(), bus.trap, bus.retire_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h/%b/%h expected 0", ctrl_outs(), bus.trap, bus.retire_cnt);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if ({bus.mem_req, bus.mem_we} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_fetch: got req/we %b%b expected 10", bus.mem_req, bus.mem_we);
        end
        exp_cnt = 32'd0;
    endtask

    task automatic test_alu();
        sb_run("add",  '{OP_R, 3'b000, 7'b0000000, 0, 0, 1'b0});
        sb_run("sub",  '{OP_R, 3'b000, 7'b0100000, 0, 0, 1'b0});
        sb_run("xor",  '{OP_R, 3'b100, 7'b0000000, 1, 0, 1'b0});
        sb_run("srai", '{OP_I, 3'b101, 7'b0100000, 0, 0, 1'b0});
        sb_run("addi", '{OP_I, 3'b000, 7'b0100000, 0, 0, 1'b0});
        sb_run("lui",  '{OP_LUI, 3'b111, 7'b1111111, 0, 0, 1'b0});
        sb_run("jal",  '{OP_JAL, 3'b010, 7'b0000000, 2, 0, 1'b0});
    endtask

    task automatic test_load_store();
        sb_run("load_w2",   '{OP_LOAD, 3'b010, 7'd0, 0, 2, 1'b0});
        sb_run("store_w0",  '{OP_STORE, 3'b010, 7'd0, 0, 0, 1'b0});
        sb_run("store_w3",  '{OP_STORE, 3'b010, 7'd0, 1, 3, 1'b0});
        sb_run("load_f2w0", '{OP_LOAD, 3'b000, 7'd0, 2, 0, 1'b0});
    endtask

    task automatic test_branch();
        sb_run("beq_taken",     '{OP_BRANCH, 3'b000, 7'd0, 0, 0, 1'b1});
        sb_run("bne_not_taken", '{OP_BRANCH, 3'b001, 7'd0, 0, 0, 1'b0});
        sb_run("blt_taken_w1",  '{OP_BRANCH, 3'b100, 7'd0, 1, 0, 1'b1});
    endtask

    task automatic test_illegal();
`ifdef CTRL_TRAP_EN
        logic [31:0] frozen;
        frozen = exp_cnt;
        bus.opcode = OP_ILL;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            #1 bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_chk++;
            if (bus.trap !== 1'b1 || ctrl_outs() !== '0 || bus.retire_cnt !== frozen) begin
                n_fail++;
                $display("FAIL trap_sticky: got trap %b outs %h cnt %0d expected 1/0/%0d",
                         bus.trap, ctrl_outs(), bus.retire_cnt, frozen);
            end
            @(posedge clk);
        end
        drive_reset();
        exp_cnt = 32'd0;
        n_chk++;
        if (bus.trap !== 1'b0 || bus.retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL trap_clear: got trap %b cnt %0d expected 0/0", bus.trap, bus.retire_cnt);
        end
`else
        sb_run("illegal_nop", '{OP_ILL, 3'b000, 7'd0, 0, 0, 1'b0});
        n_chk++;
        if (bus.trap !== 1'b0 || bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_refetch: got trap %b req %b expected 0/1", bus.trap, bus.mem_req);
        end
`endif
    endtask

    task automatic test_back_to_back();
        stim_t lib[7];
        stim_t seq[10];
        rec_t  obs, e;
        logic [31:0] c;
        lib[0] = '{OP_R, 3'b111, 7'b0000000, 0, 0, 1'b0};
        lib[1] = '{OP_I, 3'b101, 7'b0000000, 0, 0, 1'b0};
        lib[2] = '{OP_LOAD, 3'b010, 7'd0, 0, 0, 1'b0};
        lib[3] = '{OP_STORE, 3'b010, 7'd0, 0, 0, 1'b0};
        lib[4] = '{OP_BRANCH, 3'b000, 7'd0, 0, 0, 1'b0};
        lib[5] = '{OP_JAL, 3'b000, 7'd0, 0, 0, 1'b0};
        lib[6] = '{OP_LUI, 3'b000, 7'd0, 0, 0, 1'b0};
        c = exp_cnt;
        for (int i = 0; i < 10; i++) begin
            seq[i]    = lib[$urandom_range(0, 6)];
            seq[i].fw = $urandom_range(0, 2);
            seq[i].mw = $urandom_range(0, 2);
            seq[i].tk = 1'($urandom_range(0, 1));
            exp_q.push_back(model(seq[i], c));
            c = c + 32'd1;
        end
        for (int i = 0; i < 10; i++) begin
            run_instr(seq[i], obs);
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d] op %b: got %h expected %h", i, seq[i].op, obs, e);
            end
        end
        exp_cnt = c;
    endtask

    task automatic test_reset_in_mem();
        bus.opcode = OP_LOAD;
        bus.func3 = 3'b010;
        bus.func7 = 7'd0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (bus.mem_req !== 1'b1 || bus.retire_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL mem_wait: got req %b cnt %0d expected 1/%0d", bus.mem_req, bus.retire_cnt, exp_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({ctrl_outs(), bus.trap, bus.retire_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%b/%h expected 0", ctrl_outs(), bus.trap, bus.retire_cnt);
        end
        drive_reset();
        exp_cnt = 32'd0;
        sb_run("add_after_reset", '{OP_R, 3'b000, 7'd0, 0, 0, 1'b0});
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_in_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
